pio_edge_irq: RTL and testbench

PIO_EDGE_IRQ -- requirements
Module: pio_edge_irq

---
 rtl/pio_pkg.sv | 20 ++
 rtl/pio_debounce_bit.sv | 59 +++++
 rtl/pio_edge_irq.sv | 77 +++++++
 tb/tb_pio_edge_irq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the PIO edge-interrupt block: edge selection codes and register map.
package pio_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_RAW  = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } pio_addr_t;

   // Counter width able to hold deb_eff-1; never below one bit.
   function automatic int cnt_width(input int deb_eff);
      return (deb_eff > 1) ? $clog2(deb_eff) : 1;
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: synchroniser chain, stability counter, debounced level and
// a one-cycle edge pulse registered on the same edge that the stable level changes.
module pio_debounce_bit
   import pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = EDGE_FALL
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic stable,
   output logic edge_pulse
);

   localparam int DEB_EFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam int CW      = cnt_width(DEB_EFF);
   localparam logic [CW-1:0] CNT_TC = CW'(DEB_EFF - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   accept;
   logic                   dir_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync   = sync_q[SYNC_STAGES-1];
   assign accept = (sync != stable) && (cnt == CNT_TC);
   assign dir_ok = (EDGE_TYPE == EDGE_RISE) ? sync :
                   (EDGE_TYPE == EDGE_FALL) ? ~sync : 1'b1;

   // The counter stops at terminal count because accept resolves the mismatch there.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         stable     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         edge_pulse <= accept & dir_ok;
         if (sync == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pio_edge_irq.sv
// Debounced parallel input port with per-channel edge capture, interrupt mask
// and a registered read mux.
module pio_edge_irq
   import pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = EDGE_FALL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_mux;
   logic             wr_en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .EDGE_TYPE       (EDGE_TYPE)
      ) u_bit (
         .clk        (clk),
         .reset      (reset),
         .din        (in_port[i]),
         .sync       (raw[i]),
         .stable     (data[i]),
         .edge_pulse (edge_evt[i])
      );
   end

   assign wr_en = chipselect & ~write_n;
   assign clr   = (wr_en && address == ADDR_EDGE) ? writedata : '0;

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux = data;
         ADDR_RAW:  rd_mux = raw;
         ADDR_MASK: rd_mux = irq_mask;
         ADDR_EDGE: rd_mux = edge_capture;
         default:   rd_mux = '0;
      endcase
   end

   // New events are OR-ed in after the clear so a coincident event survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         readdata     <= '0;
      end else begin
         if (wr_en && address == ADDR_MASK) begin
            irq_mask <= writedata;
         end
         edge_capture <= (edge_capture & ~clr) | edge_evt;
         readdata     <= rd_mux;
      end
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Directed bench for pio_edge_irq: one falling-edge instance and one any-edge
// instance on a shared bus, read expectations queued and checked one cycle later.
module tb_pio_edge_irq;
   import pio_pkg::*;

   logic       clk;
   logic       reset;
   logic [1:0] address;
   logic       chipselect;
   logic       write_n;
   logic [3:0] writedata;
   logic [3:0] in_f;
   logic [3:0] in_a;
   logic [3:0] rd_f;
   logic [3:0] rd_a;
   logic       irq_f;
   logic       irq_a;

   int n_pass  = 0;
   int n_total = 0;

   logic [3:0] exp_q[$];
   string      tag_q[$];

   pio_edge_irq #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(EDGE_FALL)
   ) dut_f (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_f),
      .readdata(rd_f), .irq(irq_f)
   );

   pio_edge_irq #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(EDGE_ANY)
   ) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd_a), .irq(irq_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic rd(input bit sel, input logic [1:0] a, input string tag,
                     input logic [3:0] exp);
      address = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      chk(tag_q.pop_front(), sel ? rd_a : rd_f, exp_q.pop_front());
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 4'h0;
      in_f       = 4'b1111;
      in_a       = 4'b1111;
      repeat (3) @(negedge clk);
      chk("rst_rd_f", rd_f, 4'b0000);
      chk("rst_rd_a", rd_a, 4'b0000);
      chk("rst_irq_f", {3'b0, irq_f}, 4'b0000);

      // input held high through reset qualifies after 2+16 cycles
      reset = 1'b0;
      for (int i = 1; i <= 19; i++)
         rd(0, ADDR_DATA, $sformatf("rise_lat_%0d", i), (i == 19) ? 4'b1111 : 4'b0000);
      rd(1, ADDR_DATA, "a_data_up", 4'b1111);
      rd(0, ADDR_RAW, "raw_read", 4'b1111);
      rd(0, ADDR_EDGE, "no_cap_on_rise", 4'b0000);

      wr(ADDR_MASK, 4'b0001);
      rd(0, ADDR_MASK, "mask_read", 4'b0001);
      chk("irq_a_rise_cap", {3'b0, irq_a}, 4'b0001);
      wr(ADDR_DATA, 4'b1010);
      rd(0, ADDR_DATA, "data_ro", 4'b1111);

      // falling step on bit0: stable at 18, capture at 19
      address = ADDR_DATA;
      in_f = 4'b1110;
      for (int i = 1; i <= 19; i++) begin
         rd(0, ADDR_DATA, $sformatf("fall_lat_%0d", i), (i == 19) ? 4'b1110 : 4'b1111);
         if (i == 18) chk("irq_before_cap", {3'b0, irq_f}, 4'b0000);
         if (i == 19) chk("irq_after_cap", {3'b0, irq_f}, 4'b0001);
      end
      rd(0, ADDR_EDGE, "cap_bit0", 4'b0001);

      // 10-cycle glitch on bit2
      in_f = 4'b1010;
      repeat (10) @(negedge clk);
      in_f = 4'b1110;
      repeat (30) @(negedge clk);
      rd(0, ADDR_DATA, "glitch_data", 4'b1110);
      rd(0, ADDR_EDGE, "glitch_cap", 4'b0001);
      chk("glitch_irq", {3'b0, irq_f}, 4'b0001);

      wr(ADDR_EDGE, 4'b0001);
      chk("irq_cleared", {3'b0, irq_f}, 4'b0000);
      rd(0, ADDR_EDGE, "cap_cleared", 4'b0000);

      // clear coinciding with a bit1 edge event
      in_f = 4'b1111;
      repeat (25) @(negedge clk);
      in_f = 4'b1110;
      repeat (5) @(negedge clk);
      in_f = 4'b1100;
      repeat (18) @(negedge clk);
      wr(ADDR_EDGE, 4'b0011);
      rd(0, ADDR_EDGE, "edge_wins", 4'b0010);
      chk("irq_masked_off", {3'b0, irq_f}, 4'b0000);

      // any-edge instance: fall then rise on bit3, 40-cycle holds
      wr(ADDR_EDGE, 4'b1111);
      in_a = 4'b0111;
      for (int i = 1; i <= 20; i++)
         rd(1, ADDR_EDGE, $sformatf("any_fall_%0d", i), (i == 20) ? 4'b1000 : 4'b0000);
      repeat (20) @(negedge clk);
      wr(ADDR_EDGE, 4'b1000);
      rd(1, ADDR_EDGE, "any_cleared", 4'b0000);
      in_a = 4'b1111;
      for (int i = 1; i <= 20; i++)
         rd(1, ADDR_EDGE, $sformatf("any_rise_%0d", i), (i == 20) ? 4'b1000 : 4'b0000);
      chk("irq_a_masked", {3'b0, irq_a}, 4'b0000);

      // reset at count 8 of a bit3 fall debounce
      wr(ADDR_EDGE, 4'b1111);
      in_f = 4'b0100;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 19; i++)
         rd(0, ADDR_DATA, $sformatf("requal_%0d", i), (i == 19) ? 4'b0100 : 4'b0000);
      rd(0, ADDR_EDGE, "rst_no_cap", 4'b0000);
      rd(0, ADDR_MASK, "rst_mask", 4'b0000);
      chk("rst_irq", {3'b0, irq_f}, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
